// File: rtl/pi_link_if.sv
// pi_link_if: bundle of the link byte streams and the PI initiator bus.
//   rx_dat/rx_vld/rx_rdy : inbound framed command bytes (valid/ready)
//   tx_dat/tx_vld/tx_rdy : outbound read-data bytes (valid/ready)
//   pi_addr/pi_dato/pi_dati/pi_oe/pi_we : PI byte address, write data,
//                                         read data, read and write strobes
//   busy/err : bridge status (busy outside CMD, one-cycle bad-command pulse)
// modport master is the bridge side; modport slave is the link/target side.
interface pi_link_if;
  logic [7:0]  rx_dat;
  logic        rx_vld;
  logic        rx_rdy;
  logic [7:0]  tx_dat;
  logic        tx_vld;
  logic        tx_rdy;
  logic [31:0] pi_addr;
  logic [7:0]  pi_dato;
  logic [7:0]  pi_dati;
  logic        pi_oe;
  logic        pi_we;
  logic        busy;
  logic        err;

  modport master (
    input  rx_dat, rx_vld, tx_rdy, pi_dati,
    output rx_rdy, tx_dat, tx_vld, pi_addr, pi_dato, pi_oe, pi_we, busy, err
  );

  modport slave (
    output rx_dat, rx_vld, tx_rdy, pi_dati,
    input  rx_rdy, tx_dat, tx_vld, pi_addr, pi_dato, pi_oe, pi_we, busy, err
  );
endinterface

// File: rtl/pi_link_master.sv
// pi_link_master: byte-stream to PI bus bridge (PI initiator).
// Parses CMD/ADDR[4]/LEN[3] frames from the inbound byte stream and issues
// OE_CYC-clock single-byte read or write strobes with auto-incrementing
// address; read bytes are returned on the outbound stream.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pi_link_if.master (rx stream, tx stream, PI bus, busy, err)
// Parameter OE_CYC: strobe length in clocks, legal range 1..15.
module pi_link_master #(
  parameter int unsigned OE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  pi_link_if.master  bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 24;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned STB_W  = 4;
  localparam int unsigned HDR_W  = 3;

  localparam logic [BYTE_W-1:0] CMD_WR   = BYTE_W'(8'hA1);
  localparam logic [BYTE_W-1:0] CMD_RD   = BYTE_W'(8'hA0);
  localparam logic [HDR_W-1:0]  HDR_LAST = HDR_W'(6);
  localparam logic [STB_W-1:0]  STB_LAST = STB_W'(OE_CYC - 1);

  typedef enum logic [2:0] {
    ST_CMD,
    ST_HDR,
    ST_WR_WAIT,
    ST_WR_STB,
    ST_RD_STB,
    ST_RD_SEND
  } state_e;

  state_e              state_q,   state_d;
  logic [HDR_W-1:0]    hdr_cnt_q, hdr_cnt_d;
  logic [STB_W-1:0]    stb_cnt_q, stb_cnt_d;
  logic                is_wr_q,   is_wr_d;
  logic [LEN_W-1:0]    len_q,     len_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [BYTE_W-1:0]   dato_q,    dato_d;
  logic [BYTE_W-1:0]   tx_dat_q,  tx_dat_d;
  logic                tx_vld_q,  tx_vld_d;
  logic                oe_q,      oe_d;
  logic                we_q,      we_d;
  logic                rx_rdy_q,  rx_rdy_d;
  logic                busy_q,    busy_d;
  logic                err_q,     err_d;

  logic                rx_fire;
  logic [LEN_W-1:0]    len_dec;
  logic [LEN_W-1:0]    len_hdr;

  assign rx_fire = bus.rx_vld & rx_rdy_q;
  assign len_dec = len_q - LEN_W'(1);
  // Length as it will stand once the current header byte is shifted in.
  assign len_hdr = {len_q[LEN_W-BYTE_W-1:0], bus.rx_dat};

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    stb_cnt_d = stb_cnt_q;
    is_wr_d   = is_wr_q;
    len_d     = len_q;
    addr_d    = addr_q;
    dato_d    = dato_q;
    tx_dat_d  = tx_dat_q;
    tx_vld_d  = tx_vld_q;
    oe_d      = oe_q;
    we_d      = we_q;
    err_d     = 1'b0;

    unique case (state_q)
      ST_CMD: begin
        if (rx_fire) begin
          if (bus.rx_dat == CMD_WR || bus.rx_dat == CMD_RD) begin
            is_wr_d   = (bus.rx_dat == CMD_WR);
            hdr_cnt_d = '0;
            state_d   = ST_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_HDR: begin
        if (rx_fire) begin
          hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
          // Header bytes 0..3 build the address, 4..6 the length, MSB first.
          if (!hdr_cnt_q[2]) begin
            addr_d = {addr_q[ADDR_W-BYTE_W-1:0], bus.rx_dat};
          end else begin
            len_d = len_hdr;
          end
          if (hdr_cnt_q == HDR_LAST) begin
            if (len_hdr == '0) begin
              state_d = ST_CMD;
            end else if (is_wr_q) begin
              state_d = ST_WR_WAIT;
            end else begin
              state_d   = ST_RD_STB;
              oe_d      = 1'b1;
              stb_cnt_d = '0;
            end
          end
        end
      end

      ST_WR_WAIT: begin
        if (rx_fire) begin
          dato_d    = bus.rx_dat;
          we_d      = 1'b1;
          stb_cnt_d = '0;
          state_d   = ST_WR_STB;
        end
      end

      ST_WR_STB: begin
        if (stb_cnt_q == STB_LAST) begin
          we_d    = 1'b0;
          addr_d  = addr_q + ADDR_W'(1);
          len_d   = len_dec;
          state_d = (len_dec != '0) ? ST_WR_WAIT : ST_CMD;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end

      ST_RD_STB: begin
        // Read data is captured on the final strobe clock.
        if (stb_cnt_q == STB_LAST) begin
          oe_d     = 1'b0;
          tx_dat_d = bus.pi_dati;
          tx_vld_d = 1'b1;
          state_d  = ST_RD_SEND;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end

      ST_RD_SEND: begin
        // No further PI cycle until the pending byte leaves on tx.
        if (bus.tx_rdy) begin
          tx_vld_d = 1'b0;
          addr_d   = addr_q + ADDR_W'(1);
          len_d    = len_dec;
          if (len_dec != '0) begin
            state_d   = ST_RD_STB;
            oe_d      = 1'b1;
            stb_cnt_d = '0;
          end else begin
            state_d = ST_CMD;
          end
        end
      end

      default: state_d = ST_CMD;
    endcase

    rx_rdy_d = (state_d == ST_CMD) || (state_d == ST_HDR) || (state_d == ST_WR_WAIT);
    busy_d   = (state_d != ST_CMD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CMD;
      hdr_cnt_q <= '0;
      stb_cnt_q <= '0;
      is_wr_q   <= 1'b0;
      len_q     <= '0;
      addr_q    <= '0;
      dato_q    <= '0;
      tx_dat_q  <= '0;
      tx_vld_q  <= 1'b0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      rx_rdy_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      is_wr_q   <= is_wr_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      dato_q    <= dato_d;
      tx_dat_q  <= tx_dat_d;
      tx_vld_q  <= tx_vld_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      rx_rdy_q  <= rx_rdy_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus.rx_rdy  = rx_rdy_q;
  assign bus.tx_dat  = tx_dat_q;
  assign bus.tx_vld  = tx_vld_q;
  assign bus.pi_addr = addr_q;
  assign bus.pi_dato = dato_q;
  assign bus.pi_oe   = oe_q;
  assign bus.pi_we   = we_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_pi_link_master.sv
// tb_pi_link_master: randomized scoreboard bench for pi_link_master.
// Stimulus pushes expected PI accesses and tx bytes from a reference memory;
// independent monitors pop and compare as the DUT strobes or sends.
module tb_pi_link_master;

  localparam int unsigned OE_CYC     = 4;
  localparam int unsigned RX_TIMEOUT = 3000;
  localparam int unsigned WAIT_BOUND = 8000;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  data;
  } pi_acc_t;

  logic clk = 1'b0;
  logic rst_n;

  pi_link_if bus ();

  pi_link_master #(.OE_CYC(OE_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  pi_acc_t     exp_pi[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  ref_mem[logic [31:0]];
  logic [7:0]  tgt_mem[logic [31:0]];
  logic [7:0]  none[$];

  int          err_seen = 0;
  int          err_exp  = 0;
  int          tx_hold  = 0;
  int unsigned tx_pct   = 100;
  int unsigned rx_gap_pct = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic abort(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
    summary_and_finish();
  endtask

  // Untouched memory returns the low byte of its address.
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a[7:0];
  endfunction

  function automatic logic [7:0] tgt_rd(input logic [31:0] a);
    return tgt_mem.exists(a) ? tgt_mem[a] : a[7:0];
  endfunction

  // PI target: read data follows the presented address.
  always @(negedge clk) bus.pi_dati = tgt_rd(bus.pi_addr);

  // PI monitor: strobe kind/address/data, stability, width, exclusivity.
  bit          pi_prev = 1'b0;
  int          pi_width = 0;
  bit          pi_cur_wr;
  logic [31:0] pi_cur_addr;
  logic [7:0]  pi_cur_dato;
  always @(negedge clk) begin
    pi_acc_t e;
    if (!rst_n) begin
      pi_prev  = 1'b0;
      pi_width = 0;
    end else begin
      if (bus.pi_oe || bus.pi_we)
        chk("oe_we_exclusive", 32'(bus.pi_oe & bus.pi_we), 32'd0);
      if ((bus.pi_oe || bus.pi_we) && !pi_prev) begin
        pi_width    = 1;
        pi_cur_wr   = bus.pi_we;
        pi_cur_addr = bus.pi_addr;
        pi_cur_dato = bus.pi_dato;
        if (exp_pi.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe: we=%0b addr=0x%0h, expected no access", bus.pi_we, bus.pi_addr);
        end else begin
          e = exp_pi.pop_front();
          chk("pi_kind", 32'(bus.pi_we), 32'(e.wr));
          chk("pi_addr", bus.pi_addr, e.addr);
          if (e.wr) chk("pi_dato", 32'(bus.pi_dato), 32'(e.data));
        end
        if (bus.pi_we) tgt_mem[bus.pi_addr] = bus.pi_dato;
      end else if ((bus.pi_oe || bus.pi_we) && pi_prev) begin
        pi_width++;
        chk("pi_addr_stable", bus.pi_addr, pi_cur_addr);
        if (pi_cur_wr) chk("pi_dato_stable", 32'(bus.pi_dato), 32'(pi_cur_dato));
      end else if (pi_prev) begin
        chk("strobe_width", 32'(pi_width), 32'(OE_CYC));
      end
      pi_prev = bus.pi_oe || bus.pi_we;
    end
  end

  // tx sink: drives tx_rdy, checks hold under backpressure and byte order.
  bit         tx_pend = 1'b0;
  logic [7:0] tx_pend_dat;
  always @(negedge clk) begin
    logic [7:0] d;
    if (!rst_n) begin
      bus.tx_rdy = 1'b0;
      tx_pend    = 1'b0;
    end else begin
      if (tx_pend) begin
        chk("tx_vld_hold", 32'(bus.tx_vld), 32'd1);
        chk("tx_dat_hold", 32'(bus.tx_dat), 32'(tx_pend_dat));
      end
      if (tx_hold > 0 && bus.tx_vld) begin
        bus.tx_rdy = 1'b0;
        tx_hold--;
      end else begin
        bus.tx_rdy = ($urandom_range(99) < tx_pct);
      end
      if (bus.tx_vld) chk("no_oe_while_tx_pending", 32'(bus.pi_oe), 32'd0);
      if (bus.tx_vld && bus.tx_rdy) begin
        tx_pend = 1'b0;
        if (exp_tx.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_tx: got 0x%0h, expected no byte", bus.tx_dat);
        end else begin
          d = exp_tx.pop_front();
          chk("tx_dat", 32'(bus.tx_dat), 32'(d));
        end
      end else begin
        tx_pend     = bus.tx_vld;
        tx_pend_dat = bus.tx_dat;
      end
    end
  end

  always @(negedge clk) if (rst_n && bus.err) err_seen++;

  // Offer one byte on rx (after an optional random gap); returns at the
  // falling edge following the accepting clock.
  task automatic send_byte(input logic [7:0] b);
    int unsigned t;
    while ($urandom_range(99) < rx_gap_pct) begin
      bus.rx_vld = 1'b0;
      @(negedge clk);
    end
    bus.rx_vld = 1'b1;
    bus.rx_dat = b;
    t = 0;
    while (!bus.rx_rdy && t < RX_TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_rdy) abort("rx_accept_timeout");
    @(negedge clk);
    bus.rx_vld = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a, input logic [23:0] n);
    send_byte(cmd);
    chk("busy_after_cmd", 32'(bus.busy), 32'd1);
    send_byte(a[31:24]);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(n[23:16]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  // Full frame: expectations come from the reference memory first.
  task automatic run_frame(input bit wr, input logic [31:0] a, input logic [23:0] n,
                           input logic [7:0] pl[$]);
    logic [7:0]  d;
    logic [31:0] ai;
    for (int i = 0; i < int'(n); i++) begin
      ai = a + 32'(i);
      if (wr) begin
        exp_pi.push_back('{wr: 1'b1, addr: ai, data: pl[i]});
        ref_mem[ai] = pl[i];
      end else begin
        d = ref_rd(ai);
        exp_pi.push_back('{wr: 1'b0, addr: ai, data: d});
        exp_tx.push_back(d);
      end
    end
    send_hdr(wr ? 8'hA1 : 8'hA0, a, n);
    if (wr) foreach (pl[i]) send_byte(pl[i]);
  endtask

  task automatic wait_idle(input string name);
    int unsigned t = 0;
    while ((bus.busy || exp_pi.size() != 0 || exp_tx.size() != 0) && t < WAIT_BOUND) begin
      @(negedge clk);
      t++;
    end
    if (t >= WAIT_BOUND) abort({name, "_idle_timeout"});
    repeat (2) @(negedge clk);
    chk({name, "_pi_left"}, 32'(exp_pi.size()), 32'd0);
    chk({name, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    chk({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({name, "_err_count"}, 32'(err_seen), 32'(err_exp));
  endtask

  initial begin
    #900000;
    abort("global_watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [31:0] a;

    rst_n      = 1'b0;
    bus.rx_vld = 1'b0;
    bus.rx_dat = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rx_rdy",  32'(bus.rx_rdy),  32'd0);
    chk("rst_tx_vld",  32'(bus.tx_vld),  32'd0);
    chk("rst_pi_oe",   32'(bus.pi_oe),   32'd0);
    chk("rst_pi_we",   32'(bus.pi_we),   32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_err",     32'(bus.err),     32'd0);
    chk("rst_pi_addr", bus.pi_addr,      32'd0);
    chk("rst_pi_dato", 32'(bus.pi_dato), 32'd0);
    chk("rst_tx_dat",  32'(bus.tx_dat),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rx_rdy", 32'(bus.rx_rdy), 32'd1);
    chk("post_rst_busy",   32'(bus.busy),   32'd0);

    // Directed write burst.
    pl = '{8'h11, 8'h22, 8'h33};
    run_frame(1'b1, 32'h0180_00F8, 24'd3, pl);
    wait_idle("wr_burst");

    // Directed read burst with backpressure on the first byte.
    tx_hold = 5;
    run_frame(1'b0, 32'h0000_0010, 24'd2, none);
    wait_idle("rd_burst");

    // Address wrap.
    run_frame(1'b0, 32'hFFFF_FFFF, 24'd2, none);
    wait_idle("rd_wrap");

    // Zero-length write: back in CMD right after the header.
    send_hdr(8'hA1, 32'h0000_1234, 24'd0);
    chk("len0_busy",   32'(bus.busy),   32'd0);
    chk("len0_rx_rdy", 32'(bus.rx_rdy), 32'd1);
    wait_idle("len0");

    // Bad command byte, then a good frame parsed from the next byte.
    err_exp++;
    send_byte(8'h55);
    chk("bad_cmd_err",  32'(bus.err),  32'd1);
    chk("bad_cmd_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("bad_cmd_err_1cyc", 32'(bus.err), 32'd0);
    run_frame(1'b0, 32'h0000_0020, 24'd1, none);
    wait_idle("after_bad_cmd");

    // Reset during a write strobe.
    exp_pi.push_back('{wr: 1'b1, addr: 32'h0000_0040, data: 8'hAB});
    ref_mem[32'h0000_0040] = 8'hAB;
    send_hdr(8'hA1, 32'h0000_0040, 24'd4);
    send_byte(8'hAB);
    chk("mid_we_before_rst", 32'(bus.pi_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pi_we",   32'(bus.pi_we),  32'd0);
    chk("mid_rst_busy",    32'(bus.busy),   32'd0);
    chk("mid_rst_rx_rdy",  32'(bus.rx_rdy), 32'd0);
    chk("mid_rst_pi_addr", bus.pi_addr,     32'd0);
    chk("mid_rst_pi_dato", 32'(bus.pi_dato), 32'd0);
    exp_pi.delete();
    exp_tx.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 32'h0000_003F, 24'd3, none);
    wait_idle("after_mid_rst");

    // Randomised 256-byte bursts with rx gaps and tx backpressure.
    tx_pct     = 60;
    rx_gap_pct = 30;
    for (int it = 0; it < 2; it++) begin
      a = (it == 0) ? $urandom : 32'hFFFF_FF80;
      pl.delete();
      for (int i = 0; i < 256; i++) pl.push_back(8'($urandom));
      run_frame(1'b1, a, 24'd256, pl);
      wait_idle("rand_wr");
      run_frame(1'b0, a, 24'd256, none);
      wait_idle("rand_rd");
    end
    run_frame(1'b0, 32'hFFFF_FF70, 24'd40, none);
    wait_idle("rand_rd_edge");

    summary_and_finish();
  end

endmodule
